// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS front end: vectors, NOP encoding,
// next-PC select encoding and the mode-preserving sequential PC helper.
package cpu_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_J    = 3'd2,
        NPC_JR   = 3'd3,
        NPC_IRQ  = 3'd4,
        NPC_EXC  = 3'd5,
        NPC_HOLD = 3'd6
    } npc_sel_e;

    // PC+4 inside the current mode: bit 31 is kept, the low 31 bits wrap.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder and target mux. Reset is handled by the owner of
// the PC register; everything below reset is resolved here:
// exc > irq_take > jr > jump > br_taken > stall > sequential.
import cpu_pkg::*;

module pc_next_sel #(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_idx_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        irq_i,
    input  logic        exc_i,
    output logic [31:0] npc_o,
    output npc_sel_e    sel_o,
    output logic        irq_take_o
);

    // The branch target's mode bit is replaced by the current PC mode.
    logic unused_br_msb;
    assign unused_br_msb = br_target_i[31];

    // Interrupts are masked in kernel mode and deferred behind any
    // redirect or stall so the squashed slot is always a clean refetch.
    assign irq_take_o = irq_i & ~pc_i[31] & ~stall_i & ~exc_i & ~jr_i
                        & ~jump_i & ~br_taken_i;

    // Priority select and target computation.
    always_comb begin
        sel_o = NPC_SEQ;
        npc_o = seq_pc(pc_i);
        if (exc_i) begin
            sel_o = NPC_EXC;
            npc_o = EXC_VEC;
        end else if (irq_take_o) begin
            sel_o = NPC_IRQ;
            npc_o = IRQ_VEC;
        end else if (jr_i) begin
            sel_o = NPC_JR;
            npc_o = jr_target_i;
        end else if (jump_i) begin
            sel_o = NPC_J;
            npc_o = {pc_i[31:28], jump_idx_i, 2'b00};
        end else if (br_taken_i) begin
            sel_o = NPC_BR;
            npc_o = {pc_i[31], br_target_i[30:0]};
        end else if (stall_i) begin
            sel_o = NPC_HOLD;
            npc_o = pc_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, drives the ROM address, registers the fetched word
// into the IF/ID latch and captures EPC on interrupt entry.
// Optional FETCH_PERF_CNT_EN adds fetch/stall event counters.
import cpu_pkg::*;

module instr_fetch #(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        irq,
    input  logic        exc,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic [31:0] epc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
`endif
    output logic        irq_ack
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] epc_q, epc_d;
    logic        irq_ack_q;
    npc_sel_e    sel;
    logic        irq_take;
    logic        redirect;

    pc_next_sel #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_sel (
        .pc_i        (pc_q),
        .stall_i     (stall),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .jump_i      (jump),
        .jump_idx_i  (jump_idx),
        .jr_i        (jr),
        .jr_target_i (jr_target),
        .irq_i       (irq),
        .exc_i       (exc),
        .npc_o       (pc_d),
        .sel_o       (sel),
        .irq_take_o  (irq_take)
    );

    assign redirect = (sel == NPC_EXC) || (sel == NPC_IRQ) || (sel == NPC_JR)
                   || (sel == NPC_J)   || (sel == NPC_BR);

    // IF/ID and EPC next state: redirects and flush squash the slot,
    // a bare stall holds it, otherwise the ROM word is latched.
    always_comb begin
        ifid_instr_d = rom_data;
        ifid_pc4_d   = seq_pc(pc_q);
        ifid_valid_d = 1'b1;
        epc_d        = epc_q;
        if (redirect || flush) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (sel == NPC_HOLD) begin
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
            ifid_valid_d = ifid_valid_q;
        end
        if (sel == NPC_IRQ) begin
            epc_d = pc_q;
        end
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_VEC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            epc_q        <= 32'h0;
            irq_ack_q    <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            epc_q        <= epc_d;
            irq_ack_q    <= irq_take;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Event counters: valid loads and stall-only cycles, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (ifid_valid_d && (sel != NPC_HOLD))
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (sel == NPC_HOLD)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
`endif

    assign rom_addr   = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign epc        = epc_q;
    assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, IRQ entry/masking/deferral,
// stall/flush/exception, mode-preserving wrap and jump targets.
`timescale 1ns/1ps
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, flush, br_taken, jump, jr, irq, exc;
    logic [31:0] br_target, jr_target;
    logic [25:0] jump_idx;
    logic [31:0] rom_addr, rom_data, ifid_instr, ifid_pc4, epc;
    logic        ifid_valid, irq_ack;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ROM model: fixed word at the reset vector, address-tagged elsewhere.
    assign rom_data = (rom_addr == 32'h8000_0000) ? 32'h0800_0003
                                                  : {rom_addr[15:0], 16'h1234};

    instr_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jump       (jump),
        .jump_idx   (jump_idx),
        .jr         (jr),
        .jr_target  (jr_target),
        .irq        (irq),
        .exc        (exc),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ifid_instr (ifid_instr),
        .ifid_pc4   (ifid_pc4),
        .ifid_valid (ifid_valid),
        .epc        (epc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall),
`endif
        .irq_ack    (irq_ack)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; br_taken = 0; jump = 0; jr = 0;
        irq = 0; exc = 0; br_target = 0; jr_target = 0; jump_idx = 0;

        // 1. reset and first fetch
        step(); step(); step();
        check("rst_pc", rom_addr, 32'h8000_0000);
        check("rst_instr", ifid_instr, 32'h0);
        check("rst_pc4", ifid_pc4, 32'h0);
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_ack", {31'b0, irq_ack}, 32'd0);
        reset = 0;
        step();
        check("f1_pc", rom_addr, 32'h8000_0004);
        check("f1_instr", ifid_instr, 32'h0800_0003);
        check("f1_valid", {31'b0, ifid_valid}, 32'd1);
        check("f1_pc4", ifid_pc4, 32'h8000_0004);

        // 2. user mode IRQ entry
        jr = 1; jr_target = 32'h0000_0100;
        step();
        check("jr_pc", rom_addr, 32'h0000_0100);
        check("jr_bubble", {31'b0, ifid_valid}, 32'd0);
        jr = 0; irq = 1;
        step();
        check("irq_pc", rom_addr, 32'h8000_0004);
        check("irq_epc", epc, 32'h0000_0100);
        check("irq_ack1", {31'b0, irq_ack}, 32'd1);
        check("irq_bubble", {31'b0, ifid_valid}, 32'd0);
        irq = 0;
        step();
        check("irq_ack0", {31'b0, irq_ack}, 32'd0);
        check("post_irq_pc", rom_addr, 32'h8000_0008);
        check("post_irq_instr", ifid_instr, 32'h0004_1234);
        check("post_irq_pc4", ifid_pc4, 32'h8000_0008);

        // 3. kernel mode masks IRQ; JR to user lets it in next cycle
        step(); step();
        check("k_pc", rom_addr, 32'h8000_0010);
        irq = 1;
        repeat (5) step();
        check("k_masked_pc", rom_addr, 32'h8000_0024);
        check("k_masked_ack", {31'b0, irq_ack}, 32'd0);
        check("k_masked_epc", epc, 32'h0000_0100);
        jr = 1; jr_target = 32'h0000_0100;
        step();
        check("k_jr_pc", rom_addr, 32'h0000_0100);
        check("k_jr_ack", {31'b0, irq_ack}, 32'd0);
        jr = 0;
        step();
        check("k_irq_pc", rom_addr, 32'h8000_0004);
        check("k_irq_ack", {31'b0, irq_ack}, 32'd1);
        irq = 0;

        // 4. branch defers a simultaneous IRQ by one cycle
        jr = 1; jr_target = 32'h0000_0200;
        step();
        jr = 0; br_taken = 1; br_target = 32'h8000_0040; irq = 1;
        step();
        check("br_pc", rom_addr, 32'h0000_0040);
        check("br_bubble", {31'b0, ifid_valid}, 32'd0);
        check("br_ack", {31'b0, irq_ack}, 32'd0);
        br_taken = 0;
        step();
        check("br_irq_pc", rom_addr, 32'h8000_0004);
        check("br_irq_epc", epc, 32'h0000_0040);
        check("br_irq_ack", {31'b0, irq_ack}, 32'd1);
        irq = 0;

        // 5. stall, flush+stall, exc+stall
        jr = 1; jr_target = 32'h0000_001C;
        step();
        jr = 0;
        step();
        check("s_pc", rom_addr, 32'h0000_0020);
        check("s_instr", ifid_instr, 32'h001C_1234);
        stall = 1;
        step(); step();
        check("st_pc", rom_addr, 32'h0000_0020);
        check("st_instr", ifid_instr, 32'h001C_1234);
        check("st_pc4", ifid_pc4, 32'h0000_0020);
        check("st_valid", {31'b0, ifid_valid}, 32'd1);
        flush = 1;
        step();
        check("fl_valid", {31'b0, ifid_valid}, 32'd0);
        check("fl_instr", ifid_instr, 32'h0);
        check("fl_pc", rom_addr, 32'h0000_0020);
        flush = 0; exc = 1;
        step();
        check("exc_pc", rom_addr, 32'h8000_0008);
        check("exc_valid", {31'b0, ifid_valid}, 32'd0);
        check("exc_epc", epc, 32'h0000_0040);
        exc = 0; stall = 0;

        // 6. mode-preserving wrap, jump target, flush without stall
        jr = 1; jr_target = 32'h7FFF_FFFC;
        step();
        jr = 0;
        step();
        check("wrap_u_pc", rom_addr, 32'h0000_0000);
        check("wrap_u_pc4", ifid_pc4, 32'h0000_0000);
        check("wrap_u_instr", ifid_instr, 32'hFFFC_1234);
        jr = 1; jr_target = 32'hFFFF_FFFC;
        step();
        jr = 0;
        step();
        check("wrap_k_pc", rom_addr, 32'h8000_0000);
        check("wrap_k_pc4", ifid_pc4, 32'h8000_0000);
        jump = 1; jump_idx = 26'h000_0123;
        step();
        check("j_pc", rom_addr, 32'h8000_048C);
        check("j_bubble", {31'b0, ifid_valid}, 32'd0);
        jump = 0; flush = 1;
        step();
        check("fl2_pc", rom_addr, 32'h8000_0490);
        check("fl2_valid", {31'b0, ifid_valid}, 32'd0);
        flush = 0;

        // reset mid-operation with a pending IRQ and exception
        irq = 1; exc = 1; reset = 1;
        step();
        check("mrst_pc", rom_addr, 32'h8000_0000);
        check("mrst_epc", epc, 32'h0);
        check("mrst_ack", {31'b0, irq_ack}, 32'd0);
        check("mrst_valid", {31'b0, ifid_valid}, 32'd0);
        irq = 0; exc = 0; reset = 0;
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch_rst", perf_fetch, 32'd0);
        step(); step();
        check("perf_fetch_2", perf_fetch, 32'd2);
        check("perf_stall_0", perf_stall, 32'd0);
        stall = 1;
        step();
        check("perf_stall_1", perf_stall, 32'd1);
        check("perf_fetch_hold", perf_fetch, 32'd2);
        stall = 0;
`else
        step();
        check("post_rst_instr", ifid_instr, 32'h0800_0003);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
